// File: rtl/rotary_encoder_emulator.sv
// Rotary encoder emulator: drives A/B quadrature phases and the active-low
// push switch from a small command queue, so the rotary decoder can be
// exercised on-board or in loopback without a physical encoder attached.
module rotary_encoder_emulator #(
    parameter int PHASE_TICKS = 4,
    parameter int HOLD_TICKS  = 100,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk_2kHZ,
    input  logic                          rst,
    input  logic                          cmd_valid,
    input  logic [1:0]                    cmd,
    output logic                          cmd_ready,
    output logic                          oA,
    output logic                          oB,
    output logic                          oSW,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;
    localparam int MAX_T  = (HOLD_TICKS > PHASE_TICKS) ? HOLD_TICKS : PHASE_TICKS;
    localparam int CNT_W  = $clog2(MAX_T) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ROT  = 2'd1;
    localparam logic [1:0] REST = 2'd2;
    localparam logic [1:0] KEY  = 2'd3;

    localparam logic [1:0] CMD_RELEASE = 2'b00;
    localparam logic [1:0] CMD_CW      = 2'b01;
    localparam logic [1:0] CMD_CCW     = 2'b10;
    localparam logic [1:0] CMD_PRESS   = 2'b11;

    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_TICKS - 1);

    // Command queue storage and bookkeeping
    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic [1:0]    head;
    logic          push;
    logic          pop;

    // Sequencer state
    logic [1:0]       state;
    logic [1:0]       phase;
    logic             dir_ccw;
    logic [CNT_W-1:0] cnt;

    // {A,B} level for a given direction and phase index, starting from rest A=B=1.
    // CW:  B falls, A falls, B rises, A rises  (A rises with B high)
    // CCW: A falls, B falls, A rises, B rises  (A falls with B high)
    function automatic logic [1:0] phase_ab(input logic ccw, input logic [1:0] p);
        logic [1:0] ab;
        ab = 2'b11;
        if (!ccw) begin
            case (p)
                2'd0:    ab = 2'b10;
                2'd1:    ab = 2'b00;
                2'd2:    ab = 2'b01;
                default: ab = 2'b11;
            endcase
        end else begin
            case (p)
                2'd0:    ab = 2'b01;
                2'd1:    ab = 2'b00;
                2'd2:    ab = 2'b10;
                default: ab = 2'b11;
            endcase
        end
        return ab;
    endfunction

    assign head      = mem[rd_ptr];
    assign cmd_ready = (count != LW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign level     = count;
    assign busy      = (state != IDLE) || (count != '0);

    // Queue storage write; contents need no reset since count gates reads
    always_ff @(posedge clk_2kHZ) begin
        if (push) begin
            mem[wr_ptr] <= cmd;
        end
    end

    // Queue pointers and occupancy, wrapping modulo FIFO_DEPTH
    always_ff @(posedge clk_2kHZ or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Waveform sequencer: outputs change on the same edge as the state/phase step
    always_ff @(posedge clk_2kHZ or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= '0;
            dir_ccw <= 1'b0;
            cnt     <= '0;
            oA      <= 1'b1;
            oB      <= 1'b1;
            oSW     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        cnt <= '0;
                        case (head)
                            CMD_CW, CMD_CCW: begin
                                state    <= ROT;
                                phase    <= 2'd0;
                                dir_ccw  <= (head == CMD_CCW);
                                {oA, oB} <= phase_ab(head == CMD_CCW, 2'd0);
                            end
                            CMD_PRESS: begin
                                state <= KEY;
                                oSW   <= 1'b0;
                            end
                            default: begin
                                state <= KEY;
                                oSW   <= 1'b1;
                            end
                        endcase
                    end
                end
                ROT: begin
                    if (cnt == PHASE_LAST) begin
                        cnt <= '0;
                        if (phase == 2'd3) begin
                            state <= REST;
                        end else begin
                            phase    <= phase + 2'd1;
                            {oA, oB} <= phase_ab(dir_ccw, phase + 2'd1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                REST: begin
                    if (cnt == PHASE_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotary_encoder_emulator.sv
// Self-checking bench for rotary_encoder_emulator: a loopback decoder model
// turns the pin waveforms back into command codes and compares them against
// a scoreboard of codes expected from the accepted commands.
module tb_rotary_encoder_emulator;

    localparam int PT    = 4;
    localparam int HT    = 100;
    localparam int DEPTH = 4;

    logic       clk_2kHZ;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       oA;
    logic       oB;
    logic       oSW;
    logic       busy;
    logic [$clog2(DEPTH):0] level;

    rotary_encoder_emulator #(
        .PHASE_TICKS (PT),
        .HOLD_TICKS  (HT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_2kHZ  (clk_2kHZ),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .oA        (oA),
        .oB        (oB),
        .oSW       (oSW),
        .busy      (busy),
        .level     (level)
    );

    initial clk_2kHZ = 1'b0;
    always #5 clk_2kHZ = ~clk_2kHZ;

    int n_checks = 0;
    int n_bad    = 0;
    int n_events = 0;
    logic [1:0] sb [$];
    logic sw_model = 1'b1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Loopback decoder model: A edge with B high gives CW/CCW, SW edges give press/release
    logic pA = 1'b1, pB = 1'b1, pSW = 1'b1;

    task automatic emit(input logic [1:0] code);
        logic [1:0] exp;
        n_events++;
        if (sb.size() == 0) begin
            check("sb_extra_event", sb.size(), 1);
        end else begin
            exp = sb.pop_front();
            check("sb_code", code, exp);
        end
    endtask

    always @(negedge clk_2kHZ) begin
        if (!rst) begin
            if ((oA != pA) || (oB != pB))
                check("ab_edges_per_step", int'(oA != pA) + int'(oB != pB), 1);
            if (oA && !pA && oB)  emit(2'b01);
            if (!oA && pA && oB)  emit(2'b10);
            if (!oSW && pSW)      emit(2'b11);
            if (oSW && !pSW)      emit(2'b00);
        end
        pA  = oA;
        pB  = oB;
        pSW = oSW;
    end

    // Offer one command, waiting (bounded) for cmd_ready; returns at accept edge + #1
    task automatic send(input logic [1:0] c);
        int tries;
        tries = 0;
        @(negedge clk_2kHZ);
        while (!cmd_ready && tries < 300) begin
            @(negedge clk_2kHZ);
            tries++;
        end
        if (!cmd_ready) begin
            check("send_ready_timeout", cmd_ready, 1);
        end else begin
            cmd_valid = 1'b1;
            cmd       = c;
            @(posedge clk_2kHZ);
            if (c == 2'b11 && sw_model) begin
                sb.push_back(2'b11);
                sw_model = 1'b0;
            end else if (c == 2'b00 && !sw_model) begin
                sb.push_back(2'b00);
                sw_model = 1'b1;
            end else if (c == 2'b01 || c == 2'b10) begin
                sb.push_back(c);
            end
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while (busy && k < bound) begin
            @(posedge clk_2kHZ);
            #1;
            k++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ev0;
        int low;
        int lvl_exp [5];
        lvl_exp = '{1, 1, 2, 3, 4};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd       = 2'b00;

        // 1. reset
        repeat (3) @(posedge clk_2kHZ);
        #1;
        check("rst_oA", oA, 1);
        check("rst_oB", oB, 1);
        check("rst_oSW", oSW, 1);
        rst = 1'b0;
        @(posedge clk_2kHZ);
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);

        // 2. single CW: B falls at 1, A at 5, B rises at 9, A at 13, idle after 5*PT+1
        ev0 = n_events;
        send(2'b01);
        for (int k = 1; k <= 5 * PT + 1; k++) begin
            @(posedge clk_2kHZ);
            #1;
            check("cw_A", oA, (k >= PT + 1 && k < 3 * PT + 1) ? 0 : 1);
            check("cw_B", oB, (k >= 1 && k < 2 * PT + 1) ? 0 : 1);
            check("cw_busy", busy, (k < 5 * PT + 1) ? 1 : 0);
        end
        repeat (3) @(posedge clk_2kHZ);
        #1;
        check("cw_events", n_events - ev0, 1);
        check("cw_sb_empty", sb.size(), 0);

        // 3. single CCW: A falls first while B stays high
        ev0 = n_events;
        send(2'b10);
        @(posedge clk_2kHZ);
        #1;
        check("ccw_A0", oA, 0);
        check("ccw_B0", oB, 1);
        wait_idle(100);
        check("ccw_events", n_events - ev0, 1);
        check("ccw_sb_empty", sb.size(), 0);

        // 4. press then release back-to-back; the IDLE pop cycle follows the hold
        ev0 = n_events;
        send(2'b11);
        send(2'b00);
        low = 0;
        while (!oSW && low < 400) begin
            low++;
            @(posedge clk_2kHZ);
            #1;
        end
        check("key_sw_low_cycles", low, HT + 1);
        wait_idle(300);
        check("key_events", n_events - ev0, 2);
        check("key_sb_empty", sb.size(), 0);

        // 5. five CW on consecutive cycles into depth-4 queue
        ev0 = n_events;
        for (int i = 0; i < 5; i++) begin
            send(2'b01);
            check("burst_level", level, lvl_exp[i]);
            check("burst_ready", cmd_ready, (lvl_exp[i] < DEPTH) ? 1 : 0);
        end
        wait_idle(5 * (5 * PT + 1) + 20);
        check("burst_events", n_events - ev0, 5);
        check("burst_sb_empty", sb.size(), 0);

        // 6. reset during phase p1 of a CW detent with two commands queued
        ev0 = n_events;
        send(2'b01);
        send(2'b01);
        send(2'b01);
        repeat (PT) @(posedge clk_2kHZ);
        #2;
        check("mid_A_p1", oA, 0);
        check("mid_B_p1", oB, 0);
        check("mid_level", level, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_A", oA, 1);
        check("mid_rst_B", oB, 1);
        check("mid_rst_SW", oSW, 1);
        sb.delete();
        sw_model = 1'b1;
        repeat (2) @(posedge clk_2kHZ);
        #1;
        rst = 1'b0;
        @(posedge clk_2kHZ);
        #1;
        check("post_rst_level", level, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_ready", cmd_ready, 1);
        repeat (40) @(posedge clk_2kHZ);
        #1;
        check("post_rst_A", oA, 1);
        check("post_rst_B", oB, 1);
        check("post_rst_events", n_events - ev0, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
